frv_wb_arbiter: RTL and testbench
=================================

Name: frv_wb_arbiter

Overview:
Parametrised Wishbone classic N-to-1 arbiter for multi-core FazyRV clusters. It merges the imem and dmem ports of one or more cores onto a single shared memory bus. Arbitration is fixed-priority or round-robin, with an optional bus-timeout watchdog. It sits between the core macros and the shared SRAM/peripheral interconnect.

Parameters:
NPORTS, 2, number of requesting masters (1..16); port 0 is the highest fixed priority.
MODE, "RR", arbitration mode: "RR" (round-robin) or "FIXED" (lowest index wins).
TIMEOUT, 0, cycles a granted transfer may wait for s_ack_i; 0 disables the watchdog.

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_in  input  1  synchronous active-low reset
m_cyc_i  input  NPORTS  master cycle request
m_stb_i  input  NPORTS  master strobe
m_we_i  input  NPORTS  master write enable
m_be_i  input  4*NPORTS  master byte enables, port k at [4k+3:4k]
m_adr_i  input  32*NPORTS  master address, port k at [32k+31:32k]
m_dat_i  input  32*NPORTS  master write data, same packing
m_ack_o  output  NPORTS  per-master acknowledge
m_err_o  output  NPORTS  per-master timeout error
m_dat_o  output  32  read data, broadcast to all masters
s_cyc_o  output  1  shared-bus cycle
s_stb_o  output  1  shared-bus strobe
s_we_o  output  1  shared-bus write enable
s_be_o  output  4  shared-bus byte enables
s_adr_o  output  32  shared-bus address
s_dat_o  output  32  shared-bus write data
s_dat_i  input  32  shared-bus read data
s_ack_i  input  1  shared-bus acknowledge

Behaviour:
- Request from port k: m_cyc_i[k] & m_stb_i[k].
- FSM has two states, IDLE and BUSY. Registered state: grant index g (log2 NPORTS bits, min 1), RR pointer p, timeout counter.
- IDLE: if any request is present, latch g per MODE and go to BUSY on the next edge. There is no bus activity in IDLE.
- FIXED: g = lowest requesting index.
- RR: g = first requesting index at or above p, wrapping modulo NPORTS.
- BUSY: s_cyc_o = s_stb_o = 1. s_we_o, s_be_o, s_adr_o and s_dat_o are muxed combinationally from port g.
- m_ack_o[g] = s_ack_i combinationally, gated by BUSY. m_ack_o is never asserted for a non-granted port.
- m_dat_o = s_dat_i at all times.
- BUSY and s_ack_i: return to IDLE on the next edge. In RR mode, p <= (g+1) mod NPORTS.
- Latency: a request seen in cycle 0 drives the bus from cycle 1. The earliest ack is cycle 1. At least one IDLE cycle separates consecutive grants.
- BUSY and m_cyc_i[g] falls (master abort): s_cyc_o and s_stb_o drop combinationally in that cycle and the FSM returns to IDLE. No ack is forwarded. p updates as on completion.
- Timeout (TIMEOUT>0): the counter clears on entering BUSY and increments each BUSY cycle without s_ack_i.
  - On the cycle the counter equals TIMEOUT-1 with no ack: m_err_o[g] = 1 for that single cycle, m_ack_o stays 0, and the FSM returns to IDLE.
  - s_ack_i in that same cycle takes precedence: normal ack, no error.
- TIMEOUT=0: m_err_o is constantly 0 and the counter logic is removed.
- NPORTS=1: the arbiter degenerates to a pass-through with the IDLE bubble. g and p are constant 0.
- Reset (rst_in=0 at an edge), including mid-transfer:
  - state IDLE, g=0, p=0, counter=0;
  - all of s_cyc_o, s_stb_o, s_we_o, s_be_o, s_adr_o, s_dat_o, m_ack_o, m_err_o read 0 after that edge.
  - When idle, s_* data outputs are driven 0, not muxed.
- A request held while another port is granted is never dropped. In RR mode, every persistent requester is granted within NPORTS grants.

Test Plan:
- NPORTS=2, FIXED; both ports request at cycle 0 with addresses 0x100 and 0x200; slave acks 2 cycles after stb.
  - s_adr_o=0x100 in cycles 1-2, m_ack_o=2'b01 in cycle 2.
  - IDLE in cycle 3.
  - s_adr_o=0x200 from cycle 4, m_ack_o=2'b10 in cycle 5.
- NPORTS=4, RR; all ports request continuously with zero-wait slave. Required grant order is 0,1,2,3,0. Each ack pulses for 1 cycle, every other cycle.
- Write from port 1: we=1, be=4'b0011, dat=0xDEADBEEF, adr=0x20. s_we_o=1, s_be_o=0011, s_dat_o=0xDEADBEEF while BUSY. m_ack_o[1] is asserted in the cycle s_ack_i is high.
- TIMEOUT=4, slave never acks. Cycles 1-4 are BUSY with m_err_o[0]=1 in cycle 4. Cycle 5 is IDLE with s_cyc_o=0. Repeat the test with s_ack_i in cycle 4: ack, no error.
- Port 0 drops m_cyc_i in cycle 2 of its transfer while port 1 is requesting. s_cyc_o=0 in cycle 2, no m_ack_o, and port 1 is granted from cycle 4.
- rst_in=0 asserted in the 2nd BUSY cycle. All outputs are 0 after the edge. Releasing reset with port 2 requesting (RR) gives a grant to port 2 starting 1 cycle after release, because p has reset to 0.

Source files
------------

// File: rtl/frv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frv_wb_arbiter
// Desc     : Wishbone classic N-to-1 arbiter (fixed priority or round-robin)
//            with an optional bus-timeout watchdog on the granted transfer.
// Revision : 1.0 - initial release
// ============================================================================
module frv_wb_arbiter #(
    parameter int    NPORTS  = 2,
    parameter string MODE    = "RR",
    parameter int    TIMEOUT = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_in,
    input  logic [NPORTS-1:0]      m_cyc_i,
    input  logic [NPORTS-1:0]      m_stb_i,
    input  logic [NPORTS-1:0]      m_we_i,
    input  logic [4*NPORTS-1:0]    m_be_i,
    input  logic [32*NPORTS-1:0]   m_adr_i,
    input  logic [32*NPORTS-1:0]   m_dat_i,
    output logic [NPORTS-1:0]      m_ack_o,
    output logic [NPORTS-1:0]      m_err_o,
    output logic [31:0]            m_dat_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [3:0]             s_be_o,
    output logic [31:0]            s_adr_o,
    output logic [31:0]            s_dat_o,
    input  logic [31:0]            s_dat_i,
    input  logic                   s_ack_i
);

    localparam int c_GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int c_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit c_RR = (MODE == "RR");

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]        r_state_q, w_state_d;
    logic [c_GW-1:0]   r_gnt_q,   w_gnt_d;
    logic [c_GW-1:0]   r_ptr_q,   w_ptr_d;

    logic [NPORTS-1:0] w_req;
    logic [c_GW-1:0]   w_pick;
    logic              w_any;
    logic [c_GW-1:0]   w_gnt_inc;

    logic              w_busy;
    logic              w_live;
    logic              w_done;
    logic              w_timeout;

    logic              w_gnt_cyc;
    logic              w_gnt_we;
    logic [3:0]        w_gnt_be;
    logic [31:0]       w_gnt_adr;
    logic [31:0]       w_gnt_dat;

    assign w_req  = m_cyc_i & m_stb_i;
    assign w_busy = (r_state_q == c_ST_BUSY);
    // An aborting master (cyc low) removes the bus cycle in the same clock.
    assign w_live = w_busy & w_gnt_cyc;

    // Two passes: first search from the pointer upward, then wrap from 0.
    // In FIXED mode the first pass has no lower bound, so it finds the lowest.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!w_any && w_req[k] && (c_RR ? (k >= int'(r_ptr_q)) : 1'b1)) begin
                w_any  = 1'b1;
                w_pick = c_GW'(k);
            end
        end
        for (int k = 0; k < NPORTS; k++) begin
            if (!w_any && w_req[k]) begin
                w_any  = 1'b1;
                w_pick = c_GW'(k);
            end
        end
    end

    always_comb begin
        w_gnt_cyc = 1'b0;
        w_gnt_we  = 1'b0;
        w_gnt_be  = '0;
        w_gnt_adr = '0;
        w_gnt_dat = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (r_gnt_q == c_GW'(k)) begin
                w_gnt_cyc = m_cyc_i[k];
                w_gnt_we  = m_we_i[k];
                w_gnt_be  = m_be_i[4*k +: 4];
                w_gnt_adr = m_adr_i[32*k +: 32];
                w_gnt_dat = m_dat_i[32*k +: 32];
            end
        end
    end

    assign w_gnt_inc = (r_gnt_q == c_GW'(NPORTS - 1)) ? '0 : r_gnt_q + c_GW'(1);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            logic [c_CW-1:0] r_cnt_q, w_cnt_d;

            always_comb begin
                w_cnt_d = r_cnt_q;
                if (!w_busy) begin
                    w_cnt_d = '0;
                end else if (!s_ack_i) begin
                    w_cnt_d = r_cnt_q + c_CW'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_in) begin
                    r_cnt_q <= '0;
                end else begin
                    r_cnt_q <= w_cnt_d;
                end
            end

            // A same-cycle ack wins over the watchdog.
            assign w_timeout = w_live & ~s_ack_i & (r_cnt_q == c_CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign w_done = w_busy & (~w_gnt_cyc | s_ack_i | w_timeout);

    always_comb begin
        w_state_d = r_state_q;
        w_gnt_d   = r_gnt_q;
        w_ptr_d   = r_ptr_q;
        if (r_state_q == c_ST_IDLE) begin
            if (w_any) begin
                w_state_d = c_ST_BUSY;
                w_gnt_d   = w_pick;
            end
        end else begin
            if (w_done) begin
                w_state_d = c_ST_IDLE;
                if (c_RR) begin
                    w_ptr_d = w_gnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_state_q <= c_ST_IDLE;
            r_gnt_q   <= '0;
            r_ptr_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_gnt_q   <= w_gnt_d;
            r_ptr_q   <= w_ptr_d;
        end
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (r_gnt_q == c_GW'(k)) begin
                m_ack_o[k] = w_live & s_ack_i;
                m_err_o[k] = w_timeout;
            end
        end
    end

    assign m_dat_o = s_dat_i;
    assign s_cyc_o = w_live;
    assign s_stb_o = w_live;
    assign s_we_o  = w_busy & w_gnt_we;
    assign s_be_o  = w_busy ? w_gnt_be  : 4'h0;
    assign s_adr_o = w_busy ? w_gnt_adr : 32'h0;
    assign s_dat_o = w_busy ? w_gnt_dat : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_frv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_frv_wb_arbiter
// Desc     : Bench for frv_wb_arbiter: a 4-port RR instance with a watchdog and
//            a 2-port FIXED instance share stimulus and are checked each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frv_wb_arbiter;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_n = 1'b0;
    logic [3:0]    cyc = '0, stb = '0, we = '0;
    logic [15:0]   be = '0;
    logic [127:0]  adr = '0, dat = '0;
    logic          ack = 1'b0;
    logic [31:0]   sdat = '0;

    logic [3:0]  a_ack, a_err;
    logic [31:0] a_mdat, a_adr, a_dat;
    logic        a_cyc, a_stb, a_we;
    logic [3:0]  a_be;

    logic [1:0]  b_ack, b_err;
    logic [31:0] b_mdat, b_adr, b_dat;
    logic        b_cyc, b_stb, b_we;
    logic [3:0]  b_be;

    frv_wb_arbiter #(.NPORTS(4), .MODE("RR"), .TIMEOUT(4)) u_dut_a (
        .clk_i(clk_i), .rst_in(rst_n),
        .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_be_i(be),
        .m_adr_i(adr), .m_dat_i(dat),
        .m_ack_o(a_ack), .m_err_o(a_err), .m_dat_o(a_mdat),
        .s_cyc_o(a_cyc), .s_stb_o(a_stb), .s_we_o(a_we), .s_be_o(a_be),
        .s_adr_o(a_adr), .s_dat_o(a_dat), .s_dat_i(sdat), .s_ack_i(ack)
    );

    frv_wb_arbiter #(.NPORTS(2), .MODE("FIXED"), .TIMEOUT(0)) u_dut_b (
        .clk_i(clk_i), .rst_in(rst_n),
        .m_cyc_i(cyc[1:0]), .m_stb_i(stb[1:0]), .m_we_i(we[1:0]), .m_be_i(be[7:0]),
        .m_adr_i(adr[63:0]), .m_dat_i(dat[63:0]),
        .m_ack_o(b_ack), .m_err_o(b_err), .m_dat_o(b_mdat),
        .s_cyc_o(b_cyc), .s_stb_o(b_stb), .s_we_o(b_we), .s_be_o(b_be),
        .s_adr_o(b_adr), .s_dat_o(b_dat), .s_dat_i(sdat), .s_ack_i(ack)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level reference: one outstanding transfer per arbiter,
    // described by (active, port, cycles waited) plus the RR start pointer.
    int mbusy[2] = '{0, 0};
    int mg[2]    = '{0, 0};
    int mp[2]    = '{0, 0};
    int mcnt[2]  = '{0, 0};

    logic        e_cyc, e_we;
    logic [3:0]  e_be, e_ack, e_err;
    logic [31:0] e_adr, e_dat;

    task automatic model_cycle(input int id);
        int  n   = (id == 0) ? 4 : 2;
        bit  rr  = (id == 0);
        int  tmo = (id == 0) ? 4 : 0;
        int  g;
        int  idx;
        bit  found;
        bit  gc;
        e_cyc = 0; e_we = 0; e_be = 0; e_adr = 0; e_dat = 0; e_ack = 0; e_err = 0;
        if (mbusy[id] != 0) begin
            g     = mg[id];
            gc    = cyc[g];
            e_cyc = gc;
            e_we  = we[g];
            e_be  = be[4*g +: 4];
            e_adr = adr[32*g +: 32];
            e_dat = dat[32*g +: 32];
            if (gc && ack) e_ack[g] = 1'b1;
            else if (gc && tmo > 0 && mcnt[id] == tmo - 1) e_err[g] = 1'b1;
            if (!gc || ack || e_err[g]) begin
                mbusy[id] = 0;
                if (rr) mp[id] = (g + 1) % n;
            end else begin
                mcnt[id]++;
            end
        end else begin
            found = 0;
            for (int k = 0; k < n; k++) begin
                idx = rr ? (mp[id] + k) % n : k;
                if (!found && cyc[idx] && stb[idx]) begin
                    found = 1; mbusy[id] = 1; mg[id] = idx; mcnt[id] = 0;
                end
            end
        end
        if (!rst_n) begin
            mbusy[id] = 0; mg[id] = 0; mp[id] = 0; mcnt[id] = 0;
        end
    endtask

    always @(negedge clk_i) begin
        model_cycle(0);
        chk("A.s_cyc", a_cyc, e_cyc);   chk("A.s_stb", a_stb, e_cyc);
        chk("A.s_we", a_we, e_we);      chk("A.s_be", a_be, e_be);
        chk("A.s_adr", a_adr, e_adr);   chk("A.s_dat", a_dat, e_dat);
        chk("A.m_ack", a_ack, e_ack);   chk("A.m_err", a_err, e_err);
        chk("A.m_dat", a_mdat, sdat);
        model_cycle(1);
        chk("B.s_cyc", b_cyc, e_cyc);   chk("B.s_stb", b_stb, e_cyc);
        chk("B.s_we", b_we, e_we);      chk("B.s_be", b_be, e_be);
        chk("B.s_adr", b_adr, e_adr);   chk("B.s_dat", b_dat, e_dat);
        chk("B.m_ack", b_ack, e_ack[1:0]); chk("B.m_err", b_err, e_err[1:0]);
        chk("B.m_dat", b_mdat, sdat);
    end

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    task automatic set_port(input int k, input bit c, input bit s, input bit w,
                            input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        cyc[k] = c; stb[k] = s; we[k] = w;
        be[4*k +: 4] = b; adr[32*k +: 32] = a; dat[32*k +: 32] = d;
    endtask

    task automatic clear_ports();
        cyc = '0; stb = '0; we = '0; be = '0; adr = '0; dat = '0; ack = 1'b0;
    endtask

    // Leaves the caller at the start of the first post-reset cycle ("cycle 0").
    task automatic do_reset();
        clear_ports();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        sdat = 32'hA5A5_0001;
        do_reset();

        // Two-port FIXED: port 0 then port 1, slave acks on the 2nd bus cycle.
        set_port(0, 1, 1, 0, 4'hF, 32'h100, 32'h0);
        set_port(1, 1, 1, 0, 4'hF, 32'h200, 32'h0);
        at_neg(); chk("t1_c0_idle", b_cyc, 1'b0);
        next_cycle(); at_neg(); chk("t1_c1_adr", b_adr, 32'h100);
        next_cycle(); ack = 1; at_neg(); chk("t1_c2_adr", b_adr, 32'h100); chk("t1_c2_ack", b_ack, 2'b01);
        next_cycle(); ack = 0; set_port(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        at_neg(); chk("t1_c3_idle", b_cyc, 1'b0);
        next_cycle(); at_neg(); chk("t1_c4_adr", b_adr, 32'h200);
        next_cycle(); ack = 1; at_neg(); chk("t1_c5_ack", b_ack, 2'b10);
        next_cycle();

        // Four-port RR with a zero-wait slave: grants rotate 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < 4; k++) set_port(k, 1, 1, 0, 4'hF, 32'h1000 + 32'(k), 32'h0);
        ack = 1;
        for (int c = 0; c < 10; c++) begin
            at_neg();
            chk("t2_ack", a_ack, (c % 2 == 1) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000);
            next_cycle();
        end

        // Write from port 1.
        do_reset();
        set_port(1, 1, 1, 1, 4'b0011, 32'h20, 32'hDEAD_BEEF);
        at_neg();
        next_cycle(); at_neg();
        chk("t3_we", a_we, 1'b1); chk("t3_be", a_be, 4'b0011);
        chk("t3_dat", a_dat, 32'hDEAD_BEEF); chk("t3_adr", a_adr, 32'h20);
        next_cycle(); ack = 1; at_neg();
        chk("t3_ack_a", a_ack, 4'b0010); chk("t3_ack_b", b_ack, 2'b10);
        next_cycle();

        // Watchdog: no ack gives an error in the 4th bus cycle; an ack there wins.
        for (int rep = 0; rep < 2; rep++) begin
            do_reset();
            set_port(0, 1, 1, 0, 4'hF, 32'h300, 32'h0);
            for (int c = 0; c < 6; c++) begin
                ack = (rep == 1 && c == 4);
                at_neg();
                if (c >= 1 && c <= 4) chk("t4_busy", a_cyc, 1'b1);
                if (c == 4) begin
                    chk("t4_err", a_err, (rep == 0) ? 4'b0001 : 4'b0000);
                    chk("t4_ack", a_ack, (rep == 0) ? 4'b0000 : 4'b0001);
                end
                if (c == 5) chk("t4_idle", a_cyc, 1'b0);
                next_cycle();
            end
        end

        // Port 0 aborts in its 2nd bus cycle; port 1 follows after one idle cycle.
        do_reset();
        set_port(0, 1, 1, 0, 4'hF, 32'h400, 32'h0);
        set_port(1, 1, 1, 0, 4'hF, 32'h500, 32'h0);
        for (int c = 0; c < 6; c++) begin
            if (c == 2) set_port(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
            ack = (c == 2 || c == 5);
            at_neg();
            if (c == 1) chk("t5_c1_adr", a_adr, 32'h400);
            if (c == 2) begin
                chk("t5_c2_cyc", a_cyc, 1'b0); chk("t5_c2_ack", a_ack, 4'b0000);
                chk("t5_c2_bcyc", b_cyc, 1'b0);
            end
            if (c == 3) chk("t5_c3_idle", a_cyc, 1'b0);
            if (c == 4) chk("t5_c4_adr", a_adr, 32'h500);
            if (c == 5) chk("t5_c5_ack", a_ack, 4'b0010);
            next_cycle();
        end

        // Reset in the 2nd bus cycle; port 2 is granted one cycle after release.
        do_reset();
        set_port(0, 1, 1, 1, 4'hF, 32'h600, 32'h1234_5678);
        at_neg();
        next_cycle(); at_neg();
        next_cycle(); rst_n = 0; at_neg(); chk("t6_pre_rst", a_cyc, 1'b1);
        next_cycle(); rst_n = 1;
        set_port(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_port(2, 1, 1, 0, 4'hF, 32'h700, 32'h0);
        at_neg();
        chk("t6_rst_outs", {a_cyc, a_stb, a_we, a_be, a_adr, a_dat, a_ack, a_err}, '0);
        next_cycle(); ack = 1; at_neg();
        chk("t6_gnt_adr", a_adr, 32'h700); chk("t6_gnt_ack", a_ack, 4'b0100);
        next_cycle();

        // Randomized traffic with aborts, stray strobes, stalls and resets.
        clear_ports();
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 7) == 0) cyc[k] = ~cyc[k];
                stb[k] = cyc[k] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
                we[k]  = 1'($urandom_range(0, 1));
                be[4*k +: 4]   = 4'($urandom_range(0, 15));
                adr[32*k +: 32] = $urandom;
                dat[32*k +: 32] = $urandom;
            end
            ack  = ($urandom_range(0, 99) < 35);
            sdat = $urandom;
            next_cycle();
        end

        at_neg();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
